nibble_serial_adder_ctrl: RTL

Multi-cycle sequencer that performs a WIDTH-bit addition by time-multiplexing one `carry_skip_4bit` slice across all nibbles of the operands, least-significant nibble first. The carry is held in a register between slices. The block trades latency for area in the Zilla arithmetic datapath, where one 4-bit carry-skip slice serves a full 32-bit word. Valid/ready handshakes on input and output let it sit between pipeline stages that can stall.

---
 rtl/zilla_adder_pkg.sv | 30 +++
 rtl/carry_skip_4bit.sv | 41 ++++
 rtl/nibble_serial_adder_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/zilla_adder_pkg.sv
// ============================================================================
// Module   : zilla_adder_pkg
// Purpose  : Shared types and sizing helpers for the nibble-serial adder
//            datapath (FSM state encoding, nibble count, index width).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package zilla_adder_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Sizing for the default 32-bit word
  localparam int DEFAULT_WIDTH = 32;
  localparam int NIBBLES       = DEFAULT_WIDTH / 4;
  localparam int NIB_IDX_W     = $clog2(NIBBLES);

  // Index width for an arbitrary operand width; never narrower than one bit
  function automatic int nib_idx_w(input int width);
    return ((width / 4) > 1) ? $clog2(width / 4) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/carry_skip_4bit.sv
// ============================================================================
// Module   : carry_skip_4bit
// Purpose  : 4-bit ripple adder with a carry-skip bypass. When every bit
//            propagates, the incoming carry is forwarded straight to cout.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module carry_skip_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout,
  output logic       o_skip
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Ripple carry chain inside the slice
  always_comb begin
    w_c    = '0;
    w_c[0] = i_cin;
    for (int k = 0; k < 4; k++) begin
      w_c[k+1] = w_g[k] | (w_p[k] & w_c[k]);
    end
  end

  assign o_sum  = w_p ^ w_c[3:0];
  assign o_skip = &w_p;
  // Bypass: with all bits propagating the carry-in is the carry-out
  assign o_cout = o_skip ? i_cin : w_c[4];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
// ============================================================================
// Module   : nibble_serial_adder_ctrl
// Purpose  : WIDTH-bit adder built by reusing one carry_skip_4bit slice over
//            all nibbles, LS nibble first, with valid/ready on both sides.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nibble_serial_adder_ctrl
  import zilla_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  input  logic                           cin,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               sum,
  output logic                           cout,
  output logic [$clog2(WIDTH/4+1)-1:0]   skip_cnt
);

  localparam int NIB    = WIDTH / 4;
  localparam int IDX_W  = nib_idx_w(WIDTH);
  localparam int SKIP_W = $clog2(NIB + 1);

  localparam logic [IDX_W-1:0]  C_IDX_LAST = IDX_W'(NIB - 1);
  localparam logic [IDX_W-1:0]  C_IDX_ONE  = IDX_W'(1);
  localparam logic [SKIP_W-1:0] C_SKIP_ONE = SKIP_W'(1);

  state_t              r_state;
  state_t              w_next;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic                r_carry;
  logic [IDX_W-1:0]    r_idx;
  logic [WIDTH-1:0]    r_sum;
  logic                r_cout;
  logic [SKIP_W-1:0]   r_skip_cnt;

  logic                w_accept;
  logic                w_last;
  logic [IDX_W+1:0]    w_base;
  logic [3:0]          w_slice_sum;
  logic                w_slice_cout;
  logic                w_slice_skip;

  // Bit offset of the active nibble
  assign w_base = {r_idx, 2'b00};
  assign w_last = (r_idx == C_IDX_LAST);

  carry_skip_4bit u_slice (
    .i_a    (r_a[w_base +: 4]),
    .i_b    (r_b[w_base +: 4]),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout),
    .o_skip (w_slice_skip)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = ~rst;
        w_accept = in_valid & ~rst;
        if (w_accept) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand capture and per-nibble result commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_skip_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a        <= a;
            r_b        <= b;
            r_carry    <= cin;
            r_idx      <= '0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_skip_cnt <= '0;
          end
        end
        ST_RUN: begin
          r_sum[w_base +: 4] <= w_slice_sum;
          r_carry            <= w_slice_cout;
          if (w_slice_skip) r_skip_cnt <= r_skip_cnt + C_SKIP_ONE;
          // Final carry is published only once the top nibble is done
          if (w_last) begin
            r_cout <= w_slice_cout;
          end else begin
            r_idx <= r_idx + C_IDX_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum      = r_sum;
  assign cout     = r_cout;
  assign skip_cnt = r_skip_cnt;

endmodule

`default_nettype wire
